// File: rtl/pc_unit.sv
// Program counter with branch/jump/return target selection, a circular
// return-address stack, and single-level exception entry/return.
module pc_unit #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(32'h0000_0180),
  localparam int unsigned      PTR_W     = $clog2(RAS_DEPTH),
  localparam int unsigned      CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_we,
  input  logic [2:0]       pc_src,
  input  logic             br_cond,
  input  logic [15:0]      imm16,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             call,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             in_exc,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam logic [2:0] SRC_SEQ    = 3'd0;
  localparam logic [2:0] SRC_BRANCH = 3'd1;
  localparam logic [2:0] SRC_JUMP   = 3'd2;
  localparam logic [2:0] SRC_JR     = 3'd3;
  localparam logic [2:0] SRC_RET    = 3'd4;

  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             in_exc_q, in_exc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic [WIDTH-1:0] ras_wdata;
  logic [PTR_W-1:0] top_idx;
  logic [WIDTH-1:0] ras_top;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;

  assign seq_pc    = pc_q + WIDTH'(4);
  assign br_target = seq_pc + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
  assign j_target  = {seq_pc[WIDTH-1:28], j_index, 2'b00};

  // ptr_q is the next free slot, so the newest entry sits one below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign ras_top = ras_mem_q[top_idx];

  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    in_exc_d  = in_exc_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ras_we    = 1'b0;
    ras_waddr = ptr_q;
    ras_wdata = seq_pc;

    if (exc) begin
      pc_d = EXC_VEC;
      if (!in_exc_q) begin
        epc_d    = pc_q;
        in_exc_d = 1'b1;
      end
    end else if (eret && in_exc_q) begin
      pc_d     = epc_q;
      in_exc_d = 1'b0;
    end else if (pc_we) begin
      case (pc_src)
        SRC_SEQ:    pc_d = seq_pc;
        SRC_BRANCH: pc_d = br_cond ? br_target : seq_pc;
        SRC_JUMP:   pc_d = j_target;
        SRC_JR:     pc_d = reg_target;
        SRC_RET: begin
          if (count_q != '0) begin
            pc_d    = ras_top;
            ptr_d   = top_idx;
            count_d = count_q - CNT_W'(1);
          end else begin
            pc_d  = reg_target;
            unf_d = 1'b1;
          end
        end
        default:    pc_d = seq_pc;
      endcase

      // A full stack overwrites its oldest slot, which is exactly ptr_q.
      if (call && (pc_src == SRC_JUMP || pc_src == SRC_JR)) begin
        ras_we = 1'b1;
        ptr_d  = ptr_q + PTR_W'(1);
        if (count_q == RAS_FULL) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_VEC;
      epc_q    <= '0;
      in_exc_q <= 1'b0;
      ptr_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      in_exc_q <= in_exc_d;
      ptr_q    <= ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Entry contents survive reset; they are hidden while the count is zero.
  always_ff @(posedge clk) begin
    if (!rst && ras_we) begin
      ras_mem_q[ras_waddr] <= ras_wdata;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = seq_pc;
  assign epc       = epc_q;
  assign in_exc    = in_exc_q;
  assign ras_count = count_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic, checked against
// a queue-based behavioural model of the PC, exception state and return stack.
module tb_pc_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, pc_we, br_cond, call, exc, eret;
  logic [2:0]  pc_src;
  logic [15:0] imm16;
  logic [25:0] j_index;
  logic [31:0] reg_target;
  logic [31:0] pc, pc_plus4, epc;
  logic        in_exc, ras_ovf, ras_unf;
  logic [2:0]  ras_count;

  pc_unit #(.WIDTH(32), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_we(pc_we), .pc_src(pc_src), .br_cond(br_cond),
    .imm16(imm16), .j_index(j_index), .reg_target(reg_target), .call(call),
    .exc(exc), .eret(eret), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .in_exc(in_exc), .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_in_exc, m_ovf, m_unf;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] p4;
    if (rst) begin
      m_pc = 32'h0; m_epc = 32'h0; m_in_exc = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0; m_ras.delete();
    end else if (exc) begin
      if (!m_in_exc) begin
        m_epc = m_pc;
        m_in_exc = 1'b1;
      end
      m_pc = 32'h180;
    end else if (eret && m_in_exc) begin
      m_pc = m_epc;
      m_in_exc = 1'b0;
    end else if (pc_we) begin
      p4 = m_pc + 32'd4;
      case (pc_src)
        3'd1: m_pc = br_cond ? p4 + 32'(int'($signed(imm16)) * 4) : p4;
        3'd2: m_pc = (p4 & 32'hF000_0000) | (32'(j_index) * 32'd4);
        3'd3: m_pc = reg_target;
        3'd4: begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else begin
            m_pc = reg_target;
            m_unf = 1'b1;
          end
        end
        default: m_pc = p4;
      endcase
      if (call && (pc_src == 3'd2 || pc_src == 3'd3)) begin
        m_ras.push_back(p4);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic we, input logic [2:0] src,
                       input logic cond, input logic [15:0] imm, input logic [25:0] ji,
                       input logic [31:0] rt, input logic c, input logic e, input logic er);
    rst = r; pc_we = we; pc_src = src; br_cond = cond; imm16 = imm;
    j_index = ji; reg_target = rt; call = c; exc = e; eret = er;
    model_step();
    @(posedge clk);
    #1;
    n_txn++;
    check("pc", 64'(pc), 64'(m_pc));
    check("pc_plus4", 64'(pc_plus4), 64'(m_pc + 32'd4));
    check("epc", 64'(epc), 64'(m_epc));
    check("in_exc", 64'(in_exc), 64'(m_in_exc));
    check("ras_count", 64'(ras_count), 64'(m_ras.size()));
    check("ras_ovf", 64'(ras_ovf), 64'(m_ovf));
    check("ras_unf", 64'(ras_unf), 64'(m_unf));
    $display("txn %0d rst=%0b we=%0b src=%0d call=%0b exc=%0b eret=%0b -> pc=%h epc=%h cnt=%0d",
             n_txn, r, we, src, c, e, er, pc, epc, ras_count);
  endtask

  initial begin
    rst = 1'b1; pc_we = 1'b0; pc_src = 3'd0; br_cond = 1'b0; imm16 = '0;
    j_index = '0; reg_target = '0; call = 1'b0; exc = 1'b0; eret = 1'b0;
    @(negedge clk);

    // Reset, sequential stepping, hold
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pc", 64'(pc), 64'h0);
    check("rst_count", 64'(ras_count), 64'h0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("seq_pc_c", 64'(pc), 64'hC);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("hold_pc_c", 64'(pc), 64'hC);

    // Branch with offset -1 word
    cycle(0, 1, 3, 0, 0, 0, 32'h100, 0, 0, 0);
    cycle(0, 1, 1, 1, 16'hFFFF, 0, 0, 0, 0, 0);
    check("br_taken", 64'(pc), 64'h100);
    cycle(0, 1, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    check("br_not_taken", 64'(pc), 64'h104);

    // Call / return / underflow
    cycle(0, 1, 3, 0, 0, 0, 32'h400, 0, 0, 0);
    cycle(0, 1, 2, 0, 0, 26'h10, 0, 1, 0, 0);
    check("jal_pc", 64'(pc), 64'h40);
    check("jal_count", 64'(ras_count), 64'h1);
    cycle(0, 1, 4, 0, 0, 0, 32'h999, 0, 0, 0);
    check("ret_pc", 64'(pc), 64'h404);
    cycle(0, 1, 4, 0, 0, 0, 32'h800, 0, 0, 0);
    check("unf_pc", 64'(pc), 64'h800);
    check("unf_flag", 64'(ras_unf), 64'h1);

    // Overflow: five calls into a four-entry stack
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 2, 0, 0, 26'(4 * (i + 1)), 0, 1, 0, 0);
    cycle(0, 1, 2, 0, 0, 26'h100, 0, 1, 0, 0);
    check("ovf_flag", 64'(ras_ovf), 64'h1);
    check("ovf_count", 64'(ras_count), 64'h4);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 4, 0, 0, 0, 32'hDEAD, 0, 0, 0);
      check("ovf_ret", 64'(pc), 64'(32'h44 - 32'(i) * 32'h10));
    end

    // Exceptions
    cycle(0, 1, 3, 0, 0, 0, 32'h200, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    check("exc_pc", 64'(pc), 64'h180);
    check("exc_epc", 64'(epc), 64'h200);
    cycle(0, 1, 2, 0, 0, 26'h5, 0, 1, 1, 0);
    check("exc2_epc", 64'(epc), 64'h200);
    check("exc2_count", 64'(ras_count), 64'h0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    check("eret_pc", 64'(pc), 64'h200);
    check("eret_in_exc", 64'(in_exc), 64'h0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    check("rst_exc_pc", 64'(pc), 64'h0);
    check("rst_exc_in_exc", 64'(in_exc), 64'h0);
    check("rst_exc_epc", 64'(epc), 64'h0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 2) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            s,
            1'($urandom),
            16'($urandom),
            26'($urandom),
            $urandom,
            1'($urandom),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 32, address width; legal range 32..64.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, >=2.
REQ-003 Parameter RESET_VEC, default 0, WIDTH-bit PC value loaded on reset.
REQ-004 Parameter EXC_VEC, default 32'h0000_0180 zero-extended to WIDTH, exception entry address.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pc_we  in  1  PC write enable (PCWriteCond*zero+PCWrite equivalent).
REQ-008 pc_src  in  3  next-PC select: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JR, 4 RET, 5-7 reserved.
REQ-009 br_cond  in  1  branch condition for BRANCH.
REQ-010 imm16  in  16  branch offset, in words.
REQ-011 j_index  in  26  jump index field.
REQ-012 reg_target  in  WIDTH  register-sourced target for JR, and RET fallback.
REQ-013 call  in  1  push return address; honoured only with pc_we and pc_src JUMP or JR.
REQ-014 exc  in  1  exception request.
REQ-015 eret  in  1  exception return request.
REQ-016 pc  out  WIDTH  current PC, registered.
REQ-017 pc_plus4  out  WIDTH  combinational pc+4, modulo 2^WIDTH.
REQ-018 epc  out  WIDTH  saved exception PC, registered.
REQ-019 in_exc  out  1  exception-mode flag, registered.
REQ-020 ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH.
REQ-021 ras_ovf  out  1  sticky: a push occurred while full.
REQ-022 ras_unf  out  1  sticky: a RET occurred while empty.

Function
REQ-023 Priority per cycle SHALL be rst > exc > eret > pc_we > hold.
REQ-024 With pc_we=1, next pc SHALL be: SEQ pc_plus4; BRANCH br_cond ? pc_plus4+(sext(imm16)<<2) : pc_plus4; JUMP {pc_plus4[WIDTH-1:28], j_index, 2'b00}; JR reg_target; RET RAS top if ras_count>0 else reg_target; reserved pc_plus4.
REQ-025 All address arithmetic SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-026 With pc_we=0 and no exc/eret, pc, epc, in_exc and RAS SHALL hold.
REQ-027 call=1 with pc_we=1 and pc_src JUMP/JR SHALL push pc_plus4 (value before update) onto RAS; call in any other case SHALL be ignored.
REQ-028 Push when ras_count<RAS_DEPTH SHALL increment ras_count; push when full SHALL overwrite oldest entry (circular), keep ras_count=RAS_DEPTH, set ras_ovf.
REQ-029 RET with pc_we=1 and ras_count>0 SHALL pop top and decrement ras_count; RET when empty SHALL use reg_target, leave ras_count=0, set ras_unf.
REQ-030 Pointer SHALL wrap modulo RAS_DEPTH; after overflow, RAS_DEPTH pops SHALL return the newest RAS_DEPTH pushes in LIFO order.
REQ-031 exc=1 with in_exc=0 SHALL set epc<=pc, pc<=EXC_VEC, in_exc<=1, regardless of pc_we.
REQ-032 exc=1 with in_exc=1 SHALL set pc<=EXC_VEC and SHALL NOT modify epc.
REQ-033 exc SHALL NOT push, pop or alter RAS state, even when call or RET is presented the same cycle.
REQ-034 eret=1 (exc=0) with in_exc=1 SHALL set pc<=epc, in_exc<=0; eret with in_exc=0 SHALL be ignored and normal pc_we update applies.
REQ-035 ras_ovf and ras_unf SHALL clear only on rst.

Reset
REQ-036 rst=1 at a rising edge SHALL set pc=RESET_VEC, epc=0, in_exc=0, ras_count=0, ras_ovf=0, ras_unf=0, RAS pointer=0, overriding all other inputs including mid-exception.
REQ-037 RAS entry contents need not be cleared; they SHALL be unobservable while ras_count=0.

Verification
REQ-038 rst, then 3 cycles pc_we=1 SEQ -> pc 0,4,8,C; pc_we=0 one cycle -> pc stays C.
REQ-039 pc=0x100, BRANCH imm16=0xFFFF br_cond=1 -> pc=0x100; br_cond=0 -> pc=0x104.
REQ-040 pc=0x400 JUMP call=1 j_index=0x10 -> pc=0x40, RAS=[0x404]; RET -> pc=0x404, ras_count=0; RET again reg_target=0x800 -> pc=0x800, ras_unf=1.
REQ-041 RAS_DEPTH=4, 5 calls from 0x0,0x10,0x20,0x30,0x40 -> ras_ovf=1, count=4; 4 RETs -> 0x44,0x34,0x24,0x14.
REQ-042 pc=0x200 exc=1 -> pc=0x180, epc=0x200, in_exc=1; exc again -> epc=0x200; eret -> pc=0x200, in_exc=0; rst with in_exc=1 -> all reset values.
